// File: rtl/alu_pipe.sv
// Two-stage pipelined signed ALU with valid/ready handshake on both sides.
// S1 holds the accepted operands; S2 holds the registered result and status flags.
module alu_pipe #(
  parameter int unsigned WORD_SIZE    = 8,
  parameter int unsigned ALU_CON_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ALU_CON_SIZE-1:0] alu_con,
  input  logic [WORD_SIZE-1:0]    data_in_1,
  input  logic [WORD_SIZE-1:0]    data_in_2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_SIZE-1:0]    data_out,
  output logic                    zero,
  output logic                    overflow,
  output logic                    carry,
  output logic                    illegal
);

  localparam int unsigned W   = WORD_SIZE;
  localparam int unsigned MSB = WORD_SIZE - 1;

  localparam logic [ALU_CON_SIZE-1:0] OP_AND = ALU_CON_SIZE'(4'b0000);
  localparam logic [ALU_CON_SIZE-1:0] OP_OR  = ALU_CON_SIZE'(4'b0001);
  localparam logic [ALU_CON_SIZE-1:0] OP_ADD = ALU_CON_SIZE'(4'b0010);
  localparam logic [ALU_CON_SIZE-1:0] OP_SUB = ALU_CON_SIZE'(4'b0110);
  localparam logic [ALU_CON_SIZE-1:0] OP_SLT = ALU_CON_SIZE'(4'b0111);
  localparam logic [ALU_CON_SIZE-1:0] OP_NOR = ALU_CON_SIZE'(4'b1111);

  logic                    s1_valid;
  logic [ALU_CON_SIZE-1:0] s1_op;
  logic [W-1:0]            s1_a;
  logic [W-1:0]            s1_b;
  logic                    s2_valid;

  logic accept;
  logic s1_advance;
  logic s2_advance;

  logic [W:0]   sum_ext;
  logic [W-1:0] res;
  logic         res_ovf;
  logic         res_cry;
  logic         res_ill;

  // Handshake: a stalled result blocks S2, a full S1 behind it blocks the input.
  always_comb begin
    s2_advance = !s2_valid || out_ready;
    s1_advance = s1_valid && s2_advance;
    in_ready   = !s1_valid || s2_advance;
    accept     = in_valid && in_ready;
  end

  // Operand stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= alu_con;
        s1_a     <= data_in_1;
        s1_b     <= data_in_2;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Result and flags from the S1 operands; SUB reuses the adder as A + ~B + 1.
  always_comb begin
    sum_ext = '0;
    res     = '0;
    res_ovf = 1'b0;
    res_cry = 1'b0;
    res_ill = 1'b0;
    case (s1_op)
      OP_ADD: begin
        sum_ext = {1'b0, s1_a} + {1'b0, s1_b};
        res     = sum_ext[W-1:0];
        res_cry = sum_ext[W];
        res_ovf = (s1_a[MSB] == s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        sum_ext = {1'b0, s1_a} + {1'b0, ~s1_b} + (W+1)'(1);
        res     = sum_ext[W-1:0];
        res_cry = sum_ext[W];
        res_ovf = (s1_a[MSB] != s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
      end
      OP_AND:  res = s1_a & s1_b;
      OP_OR:   res = s1_a | s1_b;
      OP_NOR:  res = ~(s1_a | s1_b);
      OP_SLT:  res = W'($signed(s1_a) < $signed(s1_b));
      default: res_ill = 1'b1;
    endcase
  end

  // Result stage; outputs only change when a new result is loaded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      data_out <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      carry    <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      if (s1_advance) begin
        s2_valid <= 1'b1;
        data_out <= res;
        zero     <= (res == '0);
        overflow <= res_ovf;
        carry    <= res_cry;
        illegal  <= res_ill;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes expected results on accept,
// a monitor pops and compares on every output handshake.
module tb_alu_pipe;

  typedef struct packed {
    logic [7:0] d;
    logic       z;
    logic       o;
    logic       c;
    logic       i;
  } exp_t;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001;
  localparam logic [3:0] NOR = 4'b1111;
  localparam logic [3:0] SLT = 4'b0111;
  localparam logic [3:0] ILL = 4'b0011;
  localparam int NDIR = 13;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] alu_con;
  logic [7:0] data_in_1;
  logic [7:0] data_in_2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic       zero;
  logic       overflow;
  logic       carry;
  logic       illegal;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   stall_cnt = 0;

  logic [3:0] t_op [NDIR] = '{ADD, SUB, SUB, AND, OR, NOR, SLT, SLT, ILL, ADD, SUB, ADD, SUB};
  logic [7:0] t_a  [NDIR] = '{8'h64, 8'h80, 8'h03, 8'hCA, 8'h50, 8'h0F, 8'hFD, 8'h02, 8'h05,
                              8'hFF, 8'h05, 8'h7F, 8'h00};
  logic [7:0] t_b  [NDIR] = '{8'h32, 8'h01, 8'h05, 8'hAC, 8'h0A, 8'hF0, 8'h02, 8'hFD, 8'h07,
                              8'h01, 8'h05, 8'h01, 8'h01};
  exp_t       t_exp[NDIR] = '{
    '{8'h96, 1'b0, 1'b1, 1'b0, 1'b0},
    '{8'h7F, 1'b0, 1'b1, 1'b1, 1'b0},
    '{8'hFE, 1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h88, 1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0},
    '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0},
    '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1},
    '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0},
    '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0},
    '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0},
    '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}
  };

  alu_pipe #(.WORD_SIZE(8), .ALU_CON_SIZE(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_con   (alu_con),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .zero      (zero),
    .overflow  (overflow),
    .carry     (carry),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Integer-domain reference: range tests for overflow, magnitude compare for carry.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sb, ua, ub, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    e  = '0;
    case (op)
      ADD: begin
        r = sa + sb;
        e.d = 8'(r);
        e.o = (r > 127) || (r < -128);
        e.c = (ua + ub) > 255;
      end
      SUB: begin
        r = sa - sb;
        e.d = 8'(r);
        e.o = (r > 127) || (r < -128);
        e.c = (ua >= ub);
      end
      AND: e.d = a & b;
      OR:  e.d = a | b;
      NOR: e.d = ~(a | b);
      SLT: e.d = (sa < sb) ? 8'd1 : 8'd0;
      default: e.i = 1'b1;
    endcase
    e.z = (e.d == 8'h00);
    return e;
  endfunction

  // Present one op; inputs change only just after a rising edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input exp_t e);
    int n;
    n = 0;
    in_valid  = 1'b1;
    alu_con   = op;
    data_in_1 = a;
    data_in_2 = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      stall_cnt++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout op=%b", op);
        break;
      end
    end
    if (n <= 50) exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor
  initial begin
    forever begin
      exp_t act;
      exp_t e;
      @(negedge clk);
      if (rstn && out_valid && out_ready) begin
        act = {data_out, zero, overflow, carry, illegal};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result data=%h", data_out);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL result actual d=%h z%b o%b c%b i%b required d=%h z%b o%b c%b i%b",
                     act.d, act.z, act.o, act.c, act.i, e.d, e.z, e.o, e.c, e.i);
          end
        end
      end
    end
  end

  initial begin
    int stale;
    logic [3:0] sops [5] = '{ADD, SUB, OR, NOR, SLT};
    logic [7:0] ra, rb;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    alu_con   = '0;
    data_in_1 = '0;
    data_in_2 = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_flags", 32'({zero, overflow, carry, illegal}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, visible after edge N+1
    send(t_op[0], t_a[0], t_b[0], t_exp[0]);
    check("latency_n", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_n1", 32'(out_valid), 32'd1);
    drain();

    for (int i = 1; i < NDIR; i++) send(t_op[i], t_a[i], t_b[i], t_exp[i]);
    drain();

    // Back-to-back stream with consumer always ready
    stall_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send(sops[i % 5], ra, rb, model(sops[i % 5], ra, rb));
    end
    check("stream_no_stall", 32'(stall_cnt), 32'd0);
    drain();

    // Consumer stall with three ops offered
    fork
      begin
        send(ADD, 8'd10, 8'd20, '{8'h1E, 1'b0, 1'b0, 1'b0, 1'b0});
        send(SUB, 8'd20, 8'd10, '{8'h0A, 1'b0, 1'b0, 1'b1, 1'b0});
        send(AND, 8'hF0, 8'h3C, '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0});
      end
      begin
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk);
          if (i >= 3) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_data_hold", 32'(data_out), 32'h1E);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        #1 check("release_in_ready", 32'(in_ready), 32'd1);
      end
    join
    drain();

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(ADD, 8'd1, 8'd1, model(ADD, 8'd1, 8'd1));
    send(SUB, 8'd9, 8'd2, model(SUB, 8'd9, 8'd2));
    #2 rstn = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_data_out", 32'(data_out), 32'd0);
    check("midreset_flags", 32'({zero, overflow, carry, illegal}), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rstn      = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_after_reset", 32'(stale), 32'd0);
    @(posedge clk);
    #1;
    send(ADD, 8'd7, 8'd8, '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b0});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
